// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register placed after register_file.
// Captures operands and decoded fields with one cycle of latency. Forwards a
// same-edge writeback into the captured operands. Raises a load-use stall
// request and inserts EX bubbles. Supports downstream hold and flush.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [4:0]        A1_d,
  input  logic [4:0]        A2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [XLEN-1:0]   RD1_d,
  input  logic [XLEN-1:0]   RD2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              load_d,
  input  logic              WE3_w,
  input  logic [4:0]        A3_w,
  input  logic [XLEN-1:0]   WD3_w,
  input  logic              hold_e,
  input  logic              flush_e,
  output logic              hazard_o,
  output logic              valid_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic              load_e
);

  // Writeback forwarding. A write to x0 is never forwarded, so whatever the
  // register file supplies for x0 (always 0) passes through unchanged.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic            we,
    input logic [4:0]      a3,
    input logic [XLEN-1:0] wd,
    input logic [4:0]      a,
    input logic [XLEN-1:0] rd
  );
    return (we && (a3 != 5'd0) && (a3 == a)) ? wd : rd;
  endfunction

  // Load-use stall: a load in EX produces a register that D reads this cycle.
  always_comb begin
    hazard_o = valid_e && load_e && (rd_e != 5'd0) && valid_d &&
               ((use_rs1_d && (rd_e == A1_d)) || (use_rs2_d && (rd_e == A2_d)));
  end

  // ---- D -> E stage boundary ----
  // Priority: reset, flush, hold (with operand refresh), bubble on hazard, capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e <= 1'b0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      pc_e    <= '0;
      ctrl_e  <= '0;
      load_e  <= 1'b0;
    end else if (flush_e || (!hold_e && hazard_o)) begin
      // Bubble: every field zero, so ctrl_e=0 acts as a no-op downstream.
      valid_e <= 1'b0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      pc_e    <= '0;
      ctrl_e  <= '0;
      load_e  <= 1'b0;
    end else if (hold_e) begin
      // Held operands must still see writebacks that land while stalled.
      rd1_e <= wb_bypass(WE3_w, A3_w, WD3_w, rs1_e, rd1_e);
      rd2_e <= wb_bypass(WE3_w, A3_w, WD3_w, rs2_e, rd2_e);
    end else begin
      valid_e <= valid_d;
      rs1_e   <= A1_d;
      rs2_e   <= A2_d;
      rd_e    <= rd_d;
      rd1_e   <= wb_bypass(WE3_w, A3_w, WD3_w, A1_d, RD1_d);
      rd2_e   <= wb_bypass(WE3_w, A3_w, WD3_w, A2_d, RD2_d);
      imm_e   <= imm_d;
      pc_e    <= pc_d;
      ctrl_e  <= ctrl_d;
      load_e  <= load_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d, use_rs1_d, use_rs2_d, load_d, WE3_w, hold_e, flush_e;
  logic [4:0]  A1_d, A2_d, rd_d, A3_w;
  logic [31:0] RD1_d, RD2_d, imm_d, pc_d, WD3_w;
  logic [15:0] ctrl_d;
  logic        hazard_o, valid_e, load_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e;
  logic [15:0] ctrl_e;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .A1_d(A1_d), .A2_d(A2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d),
    .RD1_d(RD1_d), .RD2_d(RD2_d), .imm_d(imm_d), .pc_d(pc_d),
    .ctrl_d(ctrl_d), .load_d(load_d), .WE3_w(WE3_w), .A3_w(A3_w),
    .WD3_w(WD3_w), .hold_e(hold_e), .flush_e(flush_e), .hazard_o(hazard_o),
    .valid_e(valid_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
    .ctrl_e(ctrl_e), .load_e(load_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    valid_d = 0; use_rs1_d = 0; use_rs2_d = 0; load_d = 0;
    A1_d = 0; A2_d = 0; rd_d = 0; RD1_d = 0; RD2_d = 0;
    imm_d = 0; pc_d = 0; ctrl_d = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; WE3_w = 0; A3_w = 0; WD3_w = 0; hold_e = 0; flush_e = 0;
    clear_d();
    step(); step();
    chk("reset_valid", 32'(valid_e), 32'd0);
    chk("reset_hazard", 32'(hazard_o), 32'd0);
    chk("reset_rd1", rd1_e, 32'd0);
    chk("reset_ctrl", 32'(ctrl_e), 32'd0);
    rst = 0;

    // Plain capture
    valid_d = 1; A1_d = 3; A2_d = 4; rd_d = 9; RD1_d = 32'hAAAA0001;
    RD2_d = 32'h22; imm_d = 32'hFFFFFFF0; pc_d = 32'h100; ctrl_d = 16'h00A5;
    step();
    chk("cap_rd1", rd1_e, 32'hAAAA0001);
    chk("cap_imm", imm_e, 32'hFFFFFFF0);
    chk("cap_valid", 32'(valid_e), 32'd1);
    chk("cap_rs1", 32'(rs1_e), 32'd3);
    chk("cap_rd", 32'(rd_e), 32'd9);
    chk("cap_rd2", rd2_e, 32'h22);
    chk("cap_pc", pc_e, 32'h100);
    chk("cap_ctrl", 32'(ctrl_e), 32'h00A5);

    // Writeback bypass on rs1
    A1_d = 5; RD1_d = 32'h11; A2_d = 6; RD2_d = 32'h66;
    WE3_w = 1; A3_w = 5; WD3_w = 32'h99;
    step();
    chk("byp_rd1", rd1_e, 32'h99);
    chk("byp_rd2_untouched", rd2_e, 32'h66);
    // x0 write must not be forwarded
    A1_d = 0; RD1_d = 0; A3_w = 0; WD3_w = 32'h77;
    step();
    chk("byp_x0", rd1_e, 32'd0);
    // Bypass on rs2
    A1_d = 2; RD1_d = 32'h2; A2_d = 8; RD2_d = 32'h1; A3_w = 8; WD3_w = 32'hBEEF;
    step();
    chk("byp_rd2", rd2_e, 32'hBEEF);
    chk("byp_rd1_untouched", rd1_e, 32'h2);
    WE3_w = 0; A3_w = 0; WD3_w = 0;

    // Load-use hazard
    clear_d();
    valid_d = 1; load_d = 1; rd_d = 7; ctrl_d = 16'h0011;
    step();
    chk("ld_load_e", 32'(load_e), 32'd1);
    load_d = 0; rd_d = 10; ctrl_d = 16'h0022; A1_d = 1; A2_d = 7;
    use_rs1_d = 1; use_rs2_d = 0;
    #1;
    chk("ld_no_use", 32'(hazard_o), 32'd0);
    use_rs2_d = 1;
    #1;
    chk("ld_hazard", 32'(hazard_o), 32'd1);
    step();
    chk("ld_bubble_valid", 32'(valid_e), 32'd0);
    chk("ld_bubble_ctrl", 32'(ctrl_e), 32'd0);
    chk("ld_bubble_rd", 32'(rd_e), 32'd0);
    chk("ld_hazard_clear", 32'(hazard_o), 32'd0);
    step();
    chk("ld_retry_valid", 32'(valid_e), 32'd1);
    chk("ld_retry_ctrl", 32'(ctrl_e), 32'h0022);
    chk("ld_retry_rd", 32'(rd_e), 32'd10);

    // Hold with refresh
    clear_d();
    valid_d = 1; A1_d = 4; RD1_d = 32'h44; A2_d = 13; RD2_d = 32'hD;
    rd_d = 12; imm_d = 32'h1234; pc_d = 32'h200; ctrl_d = 16'h0033;
    step();
    hold_e = 1;
    A1_d = 1; RD1_d = 32'hFFFFFFFF; imm_d = 32'h9; pc_d = 32'h9; ctrl_d = 16'h9; rd_d = 3;
    step();
    chk("hold_c1_rd1", rd1_e, 32'h44);
    WE3_w = 1; A3_w = 4; WD3_w = 32'h55;
    step();
    WE3_w = 0; A3_w = 0; WD3_w = 0;
    step();
    hold_e = 0;
    chk("hold_rd1_refresh", rd1_e, 32'h55);
    chk("hold_rd2", rd2_e, 32'hD);
    chk("hold_rs1", 32'(rs1_e), 32'd4);
    chk("hold_rd", 32'(rd_e), 32'd12);
    chk("hold_imm", imm_e, 32'h1234);
    chk("hold_pc", pc_e, 32'h200);
    chk("hold_ctrl", 32'(ctrl_e), 32'h0033);
    chk("hold_valid", 32'(valid_e), 32'd1);

    // Flush overrides hold
    flush_e = 1; hold_e = 1;
    step();
    flush_e = 0; hold_e = 0;
    chk("flush_valid", 32'(valid_e), 32'd0);
    chk("flush_rd1", rd1_e, 32'd0);
    chk("flush_imm", imm_e, 32'd0);
    chk("flush_pc", pc_e, 32'd0);
    chk("flush_ctrl", 32'(ctrl_e), 32'd0);
    chk("flush_rs1", 32'(rs1_e), 32'd0);

    // Reset mid-stream is asynchronous
    clear_d();
    valid_d = 1; A1_d = 3; RD1_d = 32'h1234; pc_d = 32'h300;
    step();
    chk("pre_rst_rd1", rd1_e, 32'h1234);
    #1 rst = 1;
    #1;
    chk("async_rst_valid", 32'(valid_e), 32'd0);
    chk("async_rst_rd1", rd1_e, 32'd0);
    chk("async_rst_pc", pc_e, 32'd0);
    #1 rst = 0;
    step();
    chk("post_rst_valid", 32'(valid_e), 32'd1);
    chk("post_rst_rd1", rd1_e, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
